// File: rtl/ser_pkg.sv
// ser_pkg: serializer FSM state encodings and default payload width, shared with the detector benches
package ser_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, PARITY = 2'b10} ser_state_e;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loadable shift register; ports clk, load, shift, d -> next_bit (bit that goes on the line at the coming edge)
module piso_shift_reg
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             next_bit
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk) begin
    if (load) sr <= d;
    else if (shift) sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  end
  assign next_bit = load ? (MSB_FIRST ? d[WIDTH-1] : d[0]) : (MSB_FIRST ? sr[WIDTH-2] : sr[1]);
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready-loaded parallel-to-serial front end; ports clk rst data_in load_valid -> load_ready ser_out ser_valid busy done; SERIALIZER_PARITY_EN appends an even-parity bit
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  ser_state_e state, state_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic ser_out_n, ser_valid_n, busy_n, done_n, accept, last, shift, next_bit;
  assign load_ready = state == IDLE;
  assign accept     = load_valid && load_ready;
  assign last       = bit_cnt == CW'(WIDTH - 1);
  assign shift      = state == SHIFT && !last;
  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso (
    .clk      (clk),
    .load     (accept),
    .shift    (shift),
    .d        (data_in),
    .next_bit (next_bit)
  );
`ifdef SERIALIZER_PARITY_EN
  logic par;
  always_ff @(posedge clk) begin
    if (accept) par <= ^data_in;
  end
`endif
  always_comb begin
    state_n     = IDLE;
    cnt_n       = '0;
    ser_out_n   = IDLE_LEVEL;
    ser_valid_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_n     = SHIFT;
        ser_out_n   = next_bit;
        ser_valid_n = 1'b1;
        busy_n      = 1'b1;
      end
      SHIFT: if (!last) begin
        state_n     = SHIFT;
        cnt_n       = bit_cnt + 1'b1;
        ser_out_n   = next_bit;
        ser_valid_n = 1'b1;
        busy_n      = 1'b1;
      end
`ifdef SERIALIZER_PARITY_EN
      else begin
        state_n     = PARITY;
        ser_out_n   = par;
        ser_valid_n = 1'b1;
        busy_n      = 1'b1;
      end
      PARITY: done_n = 1'b1;
`else
      else done_n = 1'b1;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end
endmodule
